// File: rtl/kernel_tx.sv
// kernel_tx: transmit end of the kernel stream.
// Splits wide input words into STR_KER_WIDTH lanes (LSB lane first) and
// streams N lanes per armed transfer under valid/ready backpressure.
module kernel_tx #(
    parameter int                  CFG_DWIDTH    = 32,
    parameter int                  CFG_AWIDTH    = 5,
    parameter logic [CFG_AWIDTH-1:0] CFG_ADDR    = 5'd4,
    parameter int                  IN_WIDTH      = 64,
    parameter int                  STR_KER_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CFG_DWIDTH-1:0]    cfg_data,
    input  logic [CFG_AWIDTH-1:0]    cfg_addr,
    input  logic                     cfg_valid,
    input  logic [IN_WIDTH-1:0]      in_data,
    input  logic                     in_val,
    output logic                     in_rdy,
    output logic [STR_KER_WIDTH-1:0] str_ker,
    output logic                     str_ker_val,
    input  logic                     str_ker_rdy,
    output logic                     busy,
    output logic                     done
);

    localparam int RATIO  = IN_WIDTH / STR_KER_WIDTH;
    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                               state;
    logic [15:0]                              rem;
    logic [LANE_W-1:0]                        lane;
    logic [RATIO-1:0][STR_KER_WIDTH-1:0]      shift;

    logic        cfg_hit;
    logic [15:0] cfg_count;
    logic        unused_cfg;

    assign cfg_hit    = cfg_valid && (cfg_addr == CFG_ADDR);
    assign cfg_count  = cfg_data[15:0];
    // Upper config bits carry nothing for this block.
    assign unused_cfg = ^cfg_data[CFG_DWIDTH-1:16];

    // Transfer sequencer: arm on cfg, fetch a wide word, drain its lanes.
    // DONE is entered on rem==1 so the count never wraps, and leftover
    // lanes of a partial final word are simply never sent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            rem   <= '0;
            lane  <= '0;
            shift <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg_hit) begin
                        rem   <= cfg_count;
                        state <= (cfg_count != 16'd0) ? S_FETCH : S_DONE;
                    end
                end
                S_FETCH: begin
                    if (in_val) begin
                        shift <= in_data;
                        lane  <= '0;
                        state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (str_ker_rdy) begin
                        rem <= rem - 16'd1;
                        if (rem == 16'd1) begin
                            state <= S_DONE;
                        end else if (lane == LAST_LANE) begin
                            state <= S_FETCH;
                        end else begin
                            lane <= lane + LANE_W'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode from registered state only, so they fall to 0 the
    // moment reset asserts and hold steady while the stream is stalled.
    always_comb begin
        in_rdy      = (state == S_FETCH);
        str_ker_val = (state == S_SEND);
        str_ker     = (state == S_SEND) ? shift[lane] : '0;
        busy        = (state == S_FETCH) || (state == S_SEND);
        done        = (state == S_DONE);
    end

endmodule
